// File: rtl/stream_in_port.sv
// rtl/stream_in_port.sv - AXI4-Stream video receive port feeding the frame write FIFO
// Trims or flags each frame so exactly vactive lines of at most hactive pixels are written.
module stream_in_port #(
  parameter int DSIZE = 24
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [15:0]      vactive,
  input  logic [15:0]      hactive,
  input  logic [DSIZE-1:0] axi_tdata,
  input  logic             axi_tvalid,
  output logic             axi_tready,
  input  logic             axi_tuser,
  input  logic             axi_tlast,
  input  logic             fifo_full,
  output logic             wr_en,
  output logic [DSIZE-1:0] wr_data,
  output logic             falign,
  output logic             lalign,
  output logic             ealign,
  output logic             err_short,
  output logic             err_long,
  output logic             err_sof
);

  typedef enum logic [1:0] {IDLE, LINE, DROP} state_t;

  state_t           state_q, state_d;
  logic [15:0]      h_lat_q, h_lat_d, v_lat_q, v_lat_d;
  logic [15:0]      pix_cnt_q, pix_cnt_d, line_cnt_q, line_cnt_d;
  logic             frame_end_q, frame_end_d;
  logic             long_seen_q, long_seen_d;
  logic             wr_en_q, wr_en_d;
  logic [DSIZE-1:0] wr_data_q, wr_data_d;
  logic             falign_q, falign_d, lalign_q, lalign_d, ealign_q, ealign_d;
  logic             err_short_q, err_short_d, err_long_q, err_long_d, err_sof_q, err_sof_d;

  logic             accept, sof, do_write, cnt_end, tl, last_line;
  logic [15:0]      cur_pix, cur_line, cur_h, cur_v;

  assign axi_tready = ~rst & ((state_q == DROP) | ~fifo_full);
  assign accept     = axi_tvalid & axi_tready;

  always_comb begin
    state_d     = state_q;
    h_lat_d     = h_lat_q;
    v_lat_d     = v_lat_q;
    pix_cnt_d   = pix_cnt_q;
    line_cnt_d  = line_cnt_q;
    frame_end_d = frame_end_q;
    long_seen_d = long_seen_q;
    wr_en_d     = 1'b0;
    wr_data_d   = wr_data_q;
    falign_d    = 1'b0;
    lalign_d    = 1'b0;
    ealign_d    = 1'b0;
    err_short_d = 1'b0;
    err_long_d  = 1'b0;
    err_sof_d   = 1'b0;
    sof         = 1'b0;
    do_write    = 1'b0;
    cnt_end     = 1'b0;
    tl          = 1'b0;
    last_line   = 1'b0;
    cur_pix     = pix_cnt_q;
    cur_line    = line_cnt_q;
    cur_h       = h_lat_q;
    cur_v       = v_lat_q;

    // tuser wins over everything else on the same beat, in any state
    if (accept) begin
      if (axi_tuser) begin
        sof       = 1'b1;
        err_sof_d = (state_q == LINE);
        if (hactive == 16'd0 || vactive == 16'd0) begin
          state_d    = IDLE;
          pix_cnt_d  = 16'd0;
          line_cnt_d = 16'd0;
        end else begin
          do_write = 1'b1;
          h_lat_d  = hactive;
          v_lat_d  = vactive;
          cur_pix  = 16'd0;
          cur_line = 16'd0;
          cur_h    = hactive;
          cur_v    = vactive;
        end
      end else if (state_q == LINE) begin
        do_write = 1'b1;
      end else if (state_q == DROP) begin
        err_long_d  = ~long_seen_q;
        long_seen_d = 1'b1;
        if (axi_tlast) begin
          state_d = frame_end_q ? IDLE : LINE;
        end
      end
    end

    if (do_write) begin
      cnt_end   = (cur_pix == cur_h - 16'd1);
      tl        = axi_tlast & ~sof;
      wr_en_d   = 1'b1;
      wr_data_d = axi_tdata;
      falign_d  = sof;
      if (cnt_end | tl) begin
        last_line   = (cur_line == cur_v - 16'd1);
        lalign_d    = 1'b1;
        ealign_d    = last_line;
        err_short_d = tl & ~cnt_end;
        pix_cnt_d   = 16'd0;
        line_cnt_d  = cur_line + 16'd1;
        // full line without tlast: swallow the rest of the line
        if (cnt_end & ~axi_tlast) begin
          state_d     = DROP;
          frame_end_d = last_line;
          long_seen_d = 1'b0;
        end else begin
          state_d = last_line ? IDLE : LINE;
        end
      end else begin
        pix_cnt_d  = cur_pix + 16'd1;
        line_cnt_d = cur_line;
        state_d    = LINE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      h_lat_q     <= 16'd0;
      v_lat_q     <= 16'd0;
      pix_cnt_q   <= 16'd0;
      line_cnt_q  <= 16'd0;
      frame_end_q <= 1'b0;
      long_seen_q <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_data_q   <= '0;
      falign_q    <= 1'b0;
      lalign_q    <= 1'b0;
      ealign_q    <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      err_sof_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      h_lat_q     <= h_lat_d;
      v_lat_q     <= v_lat_d;
      pix_cnt_q   <= pix_cnt_d;
      line_cnt_q  <= line_cnt_d;
      frame_end_q <= frame_end_d;
      long_seen_q <= long_seen_d;
      wr_en_q     <= wr_en_d;
      wr_data_q   <= wr_data_d;
      falign_q    <= falign_d;
      lalign_q    <= lalign_d;
      ealign_q    <= ealign_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      err_sof_q   <= err_sof_d;
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_data   = wr_data_q;
  assign falign    = falign_q;
  assign lalign    = lalign_q;
  assign ealign    = ealign_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign err_sof   = err_sof_q;

endmodule

// File: tb/tb_stream_in_port.sv
// tb/tb_stream_in_port.sv - scoreboard bench for stream_in_port
// Directed frames push expected writes; a negedge monitor pops and compares.
module tb_stream_in_port;

  localparam int DSIZE = 24;

  logic             clock = 1'b0;
  logic             rst;
  logic [15:0]      vactive, hactive;
  logic [DSIZE-1:0] axi_tdata;
  logic             axi_tvalid, axi_tready, axi_tuser, axi_tlast, fifo_full;
  logic             wr_en;
  logic [DSIZE-1:0] wr_data;
  logic             falign, lalign, ealign, err_short, err_long, err_sof;

  stream_in_port #(.DSIZE(DSIZE)) dut (
    .clock(clock), .rst(rst), .vactive(vactive), .hactive(hactive),
    .axi_tdata(axi_tdata), .axi_tvalid(axi_tvalid), .axi_tready(axi_tready),
    .axi_tuser(axi_tuser), .axi_tlast(axi_tlast), .fifo_full(fifo_full),
    .wr_en(wr_en), .wr_data(wr_data), .falign(falign), .lalign(lalign),
    .ealign(ealign), .err_short(err_short), .err_long(err_long), .err_sof(err_sof)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [DSIZE-1:0] d;
    logic             f;
    logic             l;
    logic             e;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_fail = 0;
  int   n_short = 0, n_long = 0, n_sof = 0;
  logic bp_en = 1'b0;
  int   bp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clock) begin
    exp_t cur;
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {31'b0, wr_en}, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        check("wr_data", {8'b0, wr_data}, {8'b0, cur.d});
        check("f_l_e_align", {29'b0, falign, lalign, ealign}, {29'b0, cur.f, cur.l, cur.e});
      end
    end
    if (err_short) n_short++;
    if (err_long)  n_long++;
    if (err_sof)   n_sof++;
  end

  task automatic ex(input logic [DSIZE-1:0] d, input logic f, input logic l, input logic e);
    exp_t x;
    x.d = d; x.f = f; x.l = l; x.e = e;
    exp_q.push_back(x);
  endtask

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [DSIZE-1:0] d, input logic u, input logic l, input logic chk_rdy);
    logic acc;
    logic nf;
    int   tries;
    acc = 1'b0;
    tries = 0;
    axi_tdata = d; axi_tuser = u; axi_tlast = l; axi_tvalid = 1'b1;
    while (!acc && tries < 40) begin
      if (bp_en) begin
        bp_cnt++;
        if (bp_cnt % 3 == 0) fifo_full = ~fifo_full;
      end
      #1;
      nf = ~fifo_full;
      if (bp_en)   check("tready_tracks_full", {31'b0, axi_tready}, {31'b0, nf});
      if (chk_rdy) check("tready_in_drop", {31'b0, axi_tready}, 32'd1);
      acc = axi_tready;
      @(negedge clock);
      tries++;
    end
    if (!acc) check("accept_timeout", {31'b0, acc}, 32'd1);
    axi_tvalid = 1'b0; axi_tuser = 1'b0; axi_tlast = 1'b0;
  endtask

  task automatic normal_frame(input logic [DSIZE-1:0] base);
    for (int i = 0; i < 8; i++) begin
      ex(base + DSIZE'(i), i == 0, i == 3 || i == 7, i == 7);
      send(base + DSIZE'(i), i == 0, i == 3 || i == 7, 1'b0);
      if (i == 0 && bp_en) begin
        hactive = 16'd7;
        vactive = 16'd9;
      end
    end
  endtask

  task automatic end_test(input string name, input int es, input int el, input int ef);
    repeat (4) @(negedge clock);
    check({name, "_pending"}, exp_q.size(), 32'd0);
    check({name, "_err_short"}, n_short, es);
    check({name, "_err_long"}, n_long, el);
    check({name, "_err_sof"}, n_sof, ef);
    n_short = 0; n_long = 0; n_sof = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; fifo_full = 1'b0; hactive = 16'd4; vactive = 16'd2;
    axi_tdata = '0; axi_tvalid = 1'b0; axi_tuser = 1'b0; axi_tlast = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_tready", {31'b0, axi_tready}, 32'd0);
    check("reset_outputs", {2'b0, wr_en, wr_data, falign, lalign, ealign, err_short, err_long, err_sof}, 32'd0);
    rst = 1'b0;
    @(negedge clock);
    check("idle_tready", {31'b0, axi_tready}, 32'd1);

    // normal frame, then a stray non-SOF beat that must be discarded in IDLE
    normal_frame(24'h100000);
    send(24'h1000FF, 1'b0, 1'b0, 1'b0);
    end_test("normal", 0, 0, 0);

    // short first line
    ex(24'h200000, 1, 0, 0); send(24'h200000, 1'b1, 1'b0, 1'b0);
    ex(24'h200001, 0, 0, 0); send(24'h200001, 1'b0, 1'b0, 1'b0);
    ex(24'h200002, 0, 1, 0); send(24'h200002, 1'b0, 1'b1, 1'b0);
    for (int i = 3; i < 7; i++) begin
      ex(24'h200000 + DSIZE'(i), 0, i == 6, i == 6);
      send(24'h200000 + DSIZE'(i), 1'b0, i == 6, 1'b0);
    end
    end_test("short", 1, 0, 0);

    // long first line: beats 4-5 dropped even with the FIFO full
    for (int i = 0; i < 4; i++) begin
      ex(24'h300000 + DSIZE'(i), i == 0, i == 3, 0);
      send(24'h300000 + DSIZE'(i), i == 0, 1'b0, 1'b0);
    end
    fifo_full = 1'b1;
    send(24'h300004, 1'b0, 1'b0, 1'b1);
    send(24'h300005, 1'b0, 1'b1, 1'b1);
    fifo_full = 1'b0;
    for (int i = 6; i < 10; i++) begin
      ex(24'h300000 + DSIZE'(i), 0, i == 9, i == 9);
      send(24'h300000 + DSIZE'(i), 1'b0, i == 9, 1'b0);
    end
    end_test("long", 0, 1, 0);

    // tuser on the third beat of line 0 restarts the frame
    ex(24'h400000, 1, 0, 0); send(24'h400000, 1'b1, 1'b0, 1'b0);
    ex(24'h400001, 0, 0, 0); send(24'h400001, 1'b0, 1'b0, 1'b0);
    for (int i = 2; i < 10; i++) begin
      ex(24'h400000 + DSIZE'(i), i == 2, i == 5 || i == 9, i == 9);
      send(24'h400000 + DSIZE'(i), i == 2, i == 5 || i == 9, 1'b0);
    end
    end_test("mid_sof", 0, 0, 1);

    // backpressure with hactive/vactive changed after SOF
    bp_en = 1'b1; bp_cnt = 0;
    normal_frame(24'h500000);
    bp_en = 1'b0; fifo_full = 1'b0; hactive = 16'd4; vactive = 16'd2;
    end_test("backpressure", 0, 0, 0);

    // reset after write 5, orphan beats, then a clean frame
    for (int i = 0; i < 6; i++) begin
      ex(24'h600000 + DSIZE'(i), i == 0, i == 3, 0);
      send(24'h600000 + DSIZE'(i), i == 0, i == 3, 1'b0);
    end
    rst = 1'b1;
    #1;
    check("midreset_tready", {31'b0, axi_tready}, 32'd0);
    @(negedge clock);
    rst = 1'b0;
    check("midreset_outputs", {2'b0, wr_en, wr_data, falign, lalign, ealign, err_short, err_long, err_sof}, 32'd0);
    send(24'h6000A0, 1'b0, 1'b0, 1'b0);
    send(24'h6000A1, 1'b0, 1'b1, 1'b0);
    send(24'h6000A2, 1'b0, 1'b0, 1'b0);
    normal_frame(24'h700000);
    end_test("reset_mid", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
